muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, setting the operand and HI/LO width; all values below are at the default.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports input_a and input_b, input, 32, multiplicand/dividend and multiplier/divisor.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL have port div_by_zero, output, 1, one-cycle flag coincident with done for DIV/DIVU with input_b = 0.
REQ-010 The block SHALL have ports hi and lo, output, 32, result registers: product[63:32]/[31:0] for multiply, remainder/quotient for divide.

Function
REQ-011 The state machine SHALL have the states IDLE, RUN, FIX and DONE.
REQ-012 IDLE with start=1 at edge E0: latch op, input_a and input_b, take absolute values for MULT/DIV, clear the iteration counter, go to RUN; input changes after E0 have no effect.
REQ-013 Exception: IDLE with start=1 and a divide op with input_b=0 at E0 SHALL go directly to DONE with div_by_zero=1; hi/lo SHALL stay unchanged; busy SHALL stay 0.
REQ-014 RUN SHALL perform exactly one iteration per edge for 32 edges (E1..E32): shift-add multiply or restoring shift-subtract divide on unsigned magnitudes; after E32 the state SHALL be FIX.
REQ-015 FIX (edge E33) SHALL apply sign correction:
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- MULTU/DIVU: no correction.
- At E33: write hi/lo, go to DONE.
REQ-016 done SHALL be 1 exactly for the cycle between E33 and E34 (or the cycle after E0 in the REQ-013 case); DONE SHALL always return to IDLE on the next edge.
REQ-017 busy SHALL be 1 from E0 until E33, i.e. during RUN and FIX only.
REQ-018 start SHALL be ignored in RUN, FIX and DONE; exactly one done pulse SHALL occur per accepted start.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL wrap: lo=0x80000000, hi=0x00000000, with no flag.
REQ-020 hi/lo SHALL hold their last written value until the next completing operation.
REQ-021 Arithmetic SHALL be modulo 2^32 per register; the internal accumulator/remainder datapath SHALL be at least 65 bits wide, so no intermediate overflow occurs.

Reset
REQ-022 While reset=1, the block SHALL asynchronously force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0 and lo=0, and clear the counter and operand latches.
REQ-023 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-024 The first start SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-025 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high for E0..E33, done pulse after E33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-026 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-027 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-028 DIVU 5 / 0 with hi/lo previously 0x1/0x2 -> done and div_by_zero high the cycle after E0, busy stays 0, hi/lo remain 0x1/0x2.
REQ-029 reset pulsed during RUN at iteration 10 -> immediately busy=0, hi=lo=0, no done; a new MULTU 3 x 4 started afterwards -> lo=12, hi=0, after the normal latency.
REQ-030 start held high continuously across two operations -> second op accepted only at the edge after DONE; exactly one done pulse per operation, 35 edges apart.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS-style multiply/divide unit: one shift-add or
// restoring shift-subtract step per clock, with a final sign fix-up.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] input_a,
    input  logic [DATA_WIDTH-1:0] input_b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]  cnt;
    logic           is_div;
    logic           sign_a;
    logic           sign_b;
    logic           dbz_q;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [2*W:0]   p_q;

    logic           signed_in;
    logic           sa_in;
    logic           sb_in;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic           dbz_in;
    logic           last_iter;

    logic [W:0]     mul_add;
    logic [W:0]     mul_up;
    logic [2*W:0]   mul_step;
    logic [W+1:0]   rem_sh;
    logic           div_ge;
    logic [W:0]     div_rem;
    logic [2*W:0]   div_step;

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    // op[0] selects unsigned, op[1] selects divide
    assign signed_in = ~op[0];
    assign sa_in     = signed_in & input_a[W-1];
    assign sb_in     = signed_in & input_b[W-1];
    assign a_abs     = sa_in ? (~input_a + 1'b1) : input_a;
    assign b_abs     = sb_in ? (~input_b + 1'b1) : input_b;
    assign dbz_in    = op[1] && (input_b == '0);
    assign last_iter = (cnt == CW'(W - 1));

    // Multiply: {acc, multiplier} shifts right, adding a_mag when lsb set
    assign mul_add  = p_q[2*W:W] + {1'b0, a_mag};
    assign mul_up   = p_q[0] ? mul_add : p_q[2*W:W];
    assign mul_step = {1'b0, mul_up, p_q[W-1:1]};

    // Divide: {rem, quotient} shifts left, quotient bits enter at lsb
    assign rem_sh   = {p_q[2*W:W], p_q[W-1]};
    assign div_ge   = (rem_sh >= {2'b00, b_mag});
    assign div_rem  = div_ge ? (rem_sh[W:0] - {1'b0, b_mag}) : rem_sh[W:0];
    assign div_step = {div_rem, p_q[W-2:0], div_ge};

    assign prod_fix = (sign_a ^ sign_b) ? (~p_q[2*W-1:0] + 1'b1)
                                        : p_q[2*W-1:0];
    assign quo_fix  = (sign_a ^ sign_b) ? (~p_q[W-1:0] + 1'b1)
                                        : p_q[W-1:0];
    assign rem_fix  = sign_a ? (~p_q[2*W-1:W] + 1'b1) : p_q[2*W-1:W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = dbz_in ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nx = FIX;
                end
            end
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz_q  <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            p_q    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        sign_a <= sa_in;
                        sign_b <= sb_in;
                        dbz_q  <= dbz_in;
                        a_mag  <= a_abs;
                        b_mag  <= b_abs;
                        p_q    <= {{(W+1){1'b0}}, (op[1] ? a_abs : b_abs)};
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    p_q <= is_div ? div_step : mul_step;
                end
                FIX: begin
                    hi <= is_div ? rem_fix : prod_fix[2*W-1:W];
                    lo <= is_div ? quo_fix : prod_fix[W-1:0];
                end
                DONE: begin
                    dbz_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state == RUN) || (state == FIX);
    assign done        = (state == DONE);
    assign div_by_zero = (state == DONE) && dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors queue their
// expected hi/lo/flag, a negedge monitor checks every done pulse.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   done_cyc[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   exp_dones = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .input_a     (input_a),
        .input_b     (input_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clock) begin
        if (div_by_zero && !done) begin
            checks++;
            failures++;
            $display("FAIL dbz_without_done: div_by_zero=1 done=0");
        end
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
            end else begin
                mon_e = sbq.pop_front();
                chk("mon_hi", hi, mon_e.hi);
                chk("mon_lo", lo, mon_e.lo);
                chk("mon_dbz", div_by_zero, mon_e.dbz);
            end
        end
    end

    task automatic do_op(input string nm, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic dbz, input logic rel);
        int c0;
        int lat;
        int bcnt;
        @(negedge clock);
        if (rel) reset = 1'b0;
        start   = 1'b1;
        op      = o;
        input_a = a;
        input_b = b;
        sbq.push_back('{eh, el, dbz});
        exp_dones++;
        @(posedge clock);
        #1;
        c0      = cyc;
        start   = 1'b0;
        op      = ~o;
        input_a = ~a;
        input_b = ~b;
        chk({nm, "_busy_e0"}, busy, !dbz);
        lat  = -1;
        bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) begin
                lat = cyc - c0;
                break;
            end
            if (busy) bcnt++;
        end
        chk({nm, "_latency"}, lat, dbz ? 0 : 33);
        chk({nm, "_busy_cycles"}, bcnt, dbz ? 0 : 33);
        chk({nm, "_busy_at_done"}, busy, 1'b0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n0;
        int dt;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        input_a = '0;
        input_b = '0;
        @(posedge clock);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);

        do_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
        do_op("mult_m3x7", MULT, 32'hFFFFFFFD, 32'h00000007,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        do_op("div_m7d2", DIV, 32'hFFFFFFF9, 32'h00000002,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        do_op("divu_7d2", DIVU, 32'd7, 32'd2,
              32'd1, 32'd3, 1'b0, 1'b0);
        do_op("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, 1'b0, 1'b0);
        do_op("mult_7xm5", MULT, 32'd7, 32'hFFFFFFFB,
              32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0, 1'b0);
        do_op("mult_m4xm6", MULT, 32'hFFFFFFFC, 32'hFFFFFFFA,
              32'h00000000, 32'h00000018, 1'b0, 1'b0);
        do_op("div_7dm2", DIV, 32'd7, 32'hFFFFFFFE,
              32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        do_op("multu_2p32", MULTU, 32'h00010000, 32'h00010000,
              32'h00000001, 32'h00000000, 1'b0, 1'b0);
        do_op("divu_5d2", DIVU, 32'd5, 32'd2,
              32'd1, 32'd2, 1'b0, 1'b0);
        do_op("divu_5d0", DIVU, 32'd5, 32'd0,
              32'd1, 32'd2, 1'b1, 1'b0);
        do_op("div_0d0", DIV, 32'd0, 32'd0,
              32'd1, 32'd2, 1'b1, 1'b0);

        // Abandon a multiply part way through with an async reset
        @(negedge clock);
        start   = 1'b1;
        op      = MULTU;
        input_a = 32'd9;
        input_b = 32'd9;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        do_op("multu_3x4", MULTU, 32'd3, 32'd4,
              32'd0, 32'd12, 1'b0, 1'b1);

        // start held high across two back-to-back operations
        @(negedge clock);
        start   = 1'b1;
        op      = MULTU;
        input_a = 32'd3;
        input_b = 32'd5;
        sbq.push_back('{32'd0, 32'd15, 1'b0});
        sbq.push_back('{32'd0, 32'd15, 1'b0});
        exp_dones += 2;
        n0 = done_cnt;
        for (int i = 0; i < 150; i++) begin
            @(posedge clock);
            if (done_cnt >= n0 + 2) break;
        end
        #1;
        start = 1'b0;
        dt = -1;
        if (done_cnt >= n0 + 2) dt = done_cyc[n0 + 1] - done_cyc[n0];
        chk("held_start_spacing", dt, 35);

        repeat (40) @(negedge clock);
        chk("sb_empty", sbq.size(), 0);
        chk("done_count", done_cnt, exp_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
